// File: rtl/spi_responder_if.sv
// SPI pin and byte-stream bundle between the SPI master side and the responder.
interface spi_responder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             underrun;
    logic             busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
    );
endinterface

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples the master's pins on clk, shifts a local word out on
// miso MSB-first and delivers each received mosi word with a one-cycle strobe.
module spi_responder #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] FILL        = '1
) (
    input  logic           clk,
    input  logic           rst,
    spi_responder_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    // Pin synchronizers; mosi uses the same depth as sclk so the two stay aligned.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q,  sclk_dly_d;
    logic                   cs_dly_q,    cs_dly_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] tx_sh_q,    tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q,    rx_sh_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             reload_q,   reload_d;
    logic             armed_q,    armed_d;
    logic             miso_q,     miso_d;
    logic             miso_oe_q,  miso_oe_d;
    logic             tx_ready_q, tx_ready_d;
    logic [WIDTH-1:0] rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;
    logic             busy_q,     busy_d;

    logic             do_load;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] rx_word;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        cs_dly_d    = cs_sync_q[SYNC_STAGES-1];
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;

    assign load_word = bus.tx_valid ? bus.tx_data : FILL;
    assign rx_word   = {rx_sh_q[WIDTH-2:0], mosi_s};

    // Next-state and output logic. A deselect beats any sclk edge seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        armed_d    = armed_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        tx_ready_d = 1'b0;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        do_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                miso_d   = 1'b0;
                cnt_d    = '0;
                rx_sh_d  = '0;
                reload_d = 1'b0;
                armed_d  = 1'b0;
                if (cs_fall) begin
                    do_load = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    miso_d   = 1'b0;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    armed_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_sh_d = rx_word;
                    armed_d = 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        reload_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall && armed_q) begin
                    // Falls before the first rise (select taken with sclk high) are ignored.
                    if (reload_q) begin
                        do_load  = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                        miso_d  = tx_sh_q[WIDTH-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            tx_sh_d    = load_word;
            miso_d     = load_word[WIDTH-1];
            tx_ready_d = bus.tx_valid;
            underrun_d = ~bus.tx_valid;
        end

        miso_oe_d = (state_d == ACTIVE);
        busy_d    = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= IDLE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            cnt_q       <= '0;
            reload_q    <= 1'b0;
            armed_q     <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_dly_q    <= cs_dly_d;
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            cnt_q       <= cnt_d;
            reload_q    <= reload_d;
            armed_q     <= armed_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.miso     = miso_q;
    assign bus.miso_oe  = miso_oe_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.underrun = underrun_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a mode-0 master model at sclk = clk/8 with a frame table
// and hand-written back-to-back, abort and mid-frame reset sequences.
module tb_spi_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_responder_if #(.WIDTH(8)) bus ();

    spi_responder #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .FILL       (8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] tx;
        logic       txv;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];
    int   checks   = 0;
    int   failures = 0;

    // Pulse counters and the last two received words.
    int         n_txr = 0, n_rxv = 0, n_und = 0;
    logic [7:0] rx_prev = '0, rx_last = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_ready) n_txr <= n_txr + 1;
            if (bus.underrun) n_und <= n_und + 1;
            if (bus.rx_valid) begin
                n_rxv   <= n_rxv + 1;
                rx_prev <= rx_last;
                rx_last <= bus.rx_data;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " miso"},     32'(bus.miso),     0);
        check({tag, " miso_oe"},  32'(bus.miso_oe),  0);
        check({tag, " tx_ready"}, 32'(bus.tx_ready), 0);
        check({tag, " rx_data"},  32'(bus.rx_data),  0);
        check({tag, " rx_valid"}, 32'(bus.rx_valid), 0);
        check({tag, " underrun"}, 32'(bus.underrun), 0);
        check({tag, " busy"},     32'(bus.busy),     0);
    endtask

    // Master shifts nbits of mo MSB-first; samples miso just before each rise.
    // With last set, sclk is left high so the caller can drop it together with cs_n.
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                        output logic [7:0] mi);
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            bus.mosi = mo[7-k];
            wait_n(4);
            mi[7-k]  = bus.miso;
            bus.sclk = 1'b1;
            wait_n(4);
            if (k < nbits - 1 || !last) bus.sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        int         s_txr, s_rxv, s_und;
        logic [7:0] mi;
        bus.tx_data  = v.tx;
        bus.tx_valid = v.txv;
        s_txr = n_txr; s_rxv = n_rxv; s_und = n_und;
        bus.cs_n = 1'b0;
        wait_n(2);
        check({tag, " busy_early"}, 32'(bus.busy), 0);
        wait_n(1);
        check({tag, " busy_lat3"},     32'(bus.busy),     1);
        check({tag, " oe_lat3"},       32'(bus.miso_oe),  1);
        check({tag, " miso_lat3"},     32'(bus.miso),     32'(v.exp_mi[7]));
        check({tag, " tx_ready_lat3"}, 32'(bus.tx_ready), 32'(v.txv));
        check({tag, " underrun_lat3"}, 32'(bus.underrun), 32'(!v.txv));
        wait_n(1);
        xfer(v.mo, 8, 1'b1, mi);
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        wait_n(6);
        check({tag, " miso_byte"}, 32'(mi),          32'(v.exp_mi));
        check({tag, " rx_data"},   32'(bus.rx_data), 32'(v.exp_rx));
        check({tag, " oe_off"},    32'(bus.miso_oe), 0);
        check({tag, " busy_off"},  32'(bus.busy),    0);
        check({tag, " n_tx_ready"}, 32'(n_txr - s_txr), v.txv ? 1 : 0);
        check({tag, " n_underrun"}, 32'(n_und - s_und), v.txv ? 0 : 1);
        check({tag, " n_rx_valid"}, 32'(n_rxv - s_rxv), 1);
        wait_n(4);
    endtask

    initial begin
        int         s_txr, s_rxv, s_und;
        logic [7:0] m1, m2;

        vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 1'b0, 8'h96, 8'hFF, 8'h96};
        vecs[2] = '{8'h81, 1'b1, 8'h00, 8'h81, 8'h00};
        vecs[3] = '{8'h7E, 1'b1, 8'hFF, 8'h7E, 8'hFF};

        rst = 1'b1;
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;

        // Reset held while the pins toggle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.sclk = ~bus.sclk; bus.cs_n = ~bus.cs_n; bus.mosi = ~bus.mosi;
            bus.tx_valid = 1'b1;
        end
        check_reset("rst_hold");
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.tx_valid = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(8);
        check_reset("rst_release");

        for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Two frames under one select; tx_data moves on after the first load.
        bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
        s_txr = n_txr; s_rxv = n_rxv; s_und = n_und;
        bus.cs_n = 1'b0;
        wait_n(4);
        bus.tx_data = 8'h5A;
        xfer(8'h01, 8, 1'b0, m1);
        xfer(8'h80, 8, 1'b1, m2);
        bus.cs_n = 1'b1; bus.sclk = 1'b0;
        wait_n(6);
        check("b2b miso1",      32'(m1), 32'hA5);
        check("b2b miso2",      32'(m2), 32'h5A);
        check("b2b n_tx_ready", 32'(n_txr - s_txr), 2);
        check("b2b n_rx_valid", 32'(n_rxv - s_rxv), 2);
        check("b2b n_underrun", 32'(n_und - s_und), 0);
        check("b2b rx_first",   32'(rx_prev), 32'h01);
        check("b2b rx_second",  32'(rx_last), 32'h80);
        wait_n(4);

        // Abort after five rises; the partial frame must not surface.
        bus.tx_data = 8'h3C; bus.tx_valid = 1'b1;
        s_rxv = n_rxv;
        bus.cs_n = 1'b0;
        wait_n(4);
        xfer(8'hF0, 5, 1'b1, m1);
        bus.cs_n = 1'b1; bus.sclk = 1'b0;
        wait_n(6);
        check("abort n_rx_valid", 32'(n_rxv - s_rxv), 0);
        check("abort busy",       32'(bus.busy),      0);
        check("abort oe",         32'(bus.miso_oe),   0);
        check("abort rx_data",    32'(bus.rx_data),   32'h80);
        wait_n(4);
        run_frame("after_abort", '{8'h3C, 1'b1, 8'hC3, 8'h3C, 8'hC3});

        // Reset three bits into a frame.
        bus.tx_data = 8'h96; bus.tx_valid = 1'b1;
        bus.cs_n = 1'b0;
        wait_n(4);
        xfer(8'hAA, 3, 1'b0, m1);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        bus.cs_n = 1'b1; bus.sclk = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(8);
        check("rst_mid busy_after", 32'(bus.busy), 0);
        run_frame("after_rst", '{8'h96, 1'b1, 8'h5A, 8'h96, 8'h5A});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
